// File: rtl/mem_port_arbiter.sv
// Shares the CPU's single memory port between icache fills and dcache fills/writebacks,
// with a starvation guard that forces an icache grant after STARVE_LIMIT dcache grants.
module mem_port_arbiter #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    LINE_BITS      = 128,
  parameter int                    SIZE_WIDTH     = 2,
  parameter int                    STARVE_LIMIT   = 4,
  parameter logic [SIZE_WIDTH-1:0] LINE_SIZE_CODE = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  output logic                  ic_rsp_valid_o,
  output logic [LINE_BITS-1:0]  ic_rsp_data_o,
  input  logic                  dc_rd_req_i,
  input  logic                  dc_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [LINE_BITS-1:0]  dc_wr_data_i,
  input  logic [SIZE_WIDTH-1:0] dc_size_i,
  output logic                  dc_rsp_valid_o,
  output logic [LINE_BITS-1:0]  dc_rsp_data_o,
  output logic                  dc_wr_done_o,
  output logic                  mem_rd_req_valid_o,
  output logic                  mem_wr_req_valid_o,
  output logic                  mem_req_is_instr_o,
  output logic [ADDR_WIDTH-1:0] mem_req_address_o,
  output logic [LINE_BITS-1:0]  mem_wr_data_o,
  output logic [SIZE_WIDTH-1:0] mem_req_access_size_o,
  input  logic                  mem_data_valid_i,
  input  logic                  mem_data_is_instr_i,
  input  logic [LINE_BITS-1:0]  mem_data_i,
  input  logic                  mem_write_done_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, IC_RD, DC_RD, DC_WR, RESP} state_t;

  state_t                  state_q, state_d;
  logic [STREAK_W-1:0]     streak_q, streak_d;
  logic                    err_q, err_d;
  logic                    ic_rsp_valid_q, ic_rsp_valid_d;
  logic [LINE_BITS-1:0]    ic_rsp_data_q, ic_rsp_data_d;
  logic                    dc_rsp_valid_q, dc_rsp_valid_d;
  logic [LINE_BITS-1:0]    dc_rsp_data_q, dc_rsp_data_d;
  logic                    dc_wr_done_q, dc_wr_done_d;
  logic                    mem_rd_req_valid_q, mem_rd_req_valid_d;
  logic                    mem_wr_req_valid_q, mem_wr_req_valid_d;
  logic                    mem_req_is_instr_q, mem_req_is_instr_d;
  logic [ADDR_WIDTH-1:0]   mem_req_address_q, mem_req_address_d;
  logic [LINE_BITS-1:0]    mem_wr_data_q, mem_wr_data_d;
  logic [SIZE_WIDTH-1:0]   mem_req_access_size_q, mem_req_access_size_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q               <= IDLE;
      streak_q              <= '0;
      err_q                 <= 1'b0;
      ic_rsp_valid_q        <= 1'b0;
      ic_rsp_data_q         <= '0;
      dc_rsp_valid_q        <= 1'b0;
      dc_rsp_data_q         <= '0;
      dc_wr_done_q          <= 1'b0;
      mem_rd_req_valid_q    <= 1'b0;
      mem_wr_req_valid_q    <= 1'b0;
      mem_req_is_instr_q    <= 1'b0;
      mem_req_address_q     <= '0;
      mem_wr_data_q         <= '0;
      mem_req_access_size_q <= '0;
    end else begin
      state_q               <= state_d;
      streak_q              <= streak_d;
      err_q                 <= err_d;
      ic_rsp_valid_q        <= ic_rsp_valid_d;
      ic_rsp_data_q         <= ic_rsp_data_d;
      dc_rsp_valid_q        <= dc_rsp_valid_d;
      dc_rsp_data_q         <= dc_rsp_data_d;
      dc_wr_done_q          <= dc_wr_done_d;
      mem_rd_req_valid_q    <= mem_rd_req_valid_d;
      mem_wr_req_valid_q    <= mem_wr_req_valid_d;
      mem_req_is_instr_q    <= mem_req_is_instr_d;
      mem_req_address_q     <= mem_req_address_d;
      mem_wr_data_q         <= mem_wr_data_d;
      mem_req_access_size_q <= mem_req_access_size_d;
    end
  end

  // Arbitration, streak bookkeeping and protocol-error detection.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (ic_rd_req_i && (streak_q == STREAK_MAX)) begin
          state_d = IC_RD;
        end else if (dc_wr_req_i) begin
          state_d = DC_WR;
        end else if (dc_rd_req_i) begin
          state_d = DC_RD;
        end else if (ic_rd_req_i) begin
          state_d = IC_RD;
        end
        if (state_d == IC_RD) begin
          streak_d = '0;
        end else if ((state_d == DC_RD) || (state_d == DC_WR)) begin
          if (!ic_rd_req_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end
        if (mem_data_valid_i || mem_write_done_i) err_d = 1'b1;
      end
      IC_RD: begin
        if (mem_data_valid_i) begin
          state_d = RESP;
          if (!mem_data_is_instr_i) err_d = 1'b1;
        end
        if (mem_write_done_i) err_d = 1'b1;
      end
      DC_RD: begin
        if (mem_data_valid_i) begin
          state_d = RESP;
          if (mem_data_is_instr_i) err_d = 1'b1;
        end
        if (mem_write_done_i) err_d = 1'b1;
      end
      DC_WR: begin
        if (mem_write_done_i) state_d = RESP;
        if (mem_data_valid_i) err_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        if (mem_data_valid_i || mem_write_done_i) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so the request appears
  // the cycle after the grant and drops the cycle after the memory responds.
  always_comb begin
    mem_rd_req_valid_d    = (state_d == IC_RD) || (state_d == DC_RD);
    mem_wr_req_valid_d    = (state_d == DC_WR);
    mem_req_is_instr_d    = (state_d == IC_RD);
    mem_req_address_d     = '0;
    mem_wr_data_d         = '0;
    mem_req_access_size_d = '0;
    if (state_q == IDLE) begin
      case (state_d)
        IC_RD: begin
          mem_req_address_d     = ic_addr_i;
          mem_req_access_size_d = LINE_SIZE_CODE;
        end
        DC_RD: begin
          mem_req_address_d     = dc_addr_i;
          mem_req_access_size_d = dc_size_i;
        end
        DC_WR: begin
          mem_req_address_d     = dc_addr_i;
          mem_req_access_size_d = dc_size_i;
          mem_wr_data_d         = dc_wr_data_i;
        end
        default: ;
      endcase
    end else if (state_d == state_q) begin
      mem_req_address_d     = mem_req_address_q;
      mem_wr_data_d         = mem_wr_data_q;
      mem_req_access_size_d = mem_req_access_size_q;
    end

    ic_rsp_valid_d = (state_q == IC_RD) && mem_data_valid_i;
    dc_rsp_valid_d = (state_q == DC_RD) && mem_data_valid_i;
    dc_wr_done_d   = (state_q == DC_WR) && mem_write_done_i;
    ic_rsp_data_d  = ic_rsp_valid_d ? mem_data_i : ic_rsp_data_q;
    dc_rsp_data_d  = dc_rsp_valid_d ? mem_data_i : dc_rsp_data_q;
  end

  assign ic_rsp_valid_o        = ic_rsp_valid_q;
  assign ic_rsp_data_o         = ic_rsp_data_q;
  assign dc_rsp_valid_o        = dc_rsp_valid_q;
  assign dc_rsp_data_o         = dc_rsp_data_q;
  assign dc_wr_done_o          = dc_wr_done_q;
  assign mem_rd_req_valid_o    = mem_rd_req_valid_q;
  assign mem_wr_req_valid_o    = mem_wr_req_valid_q;
  assign mem_req_is_instr_o    = mem_req_is_instr_q;
  assign mem_req_address_o     = mem_req_address_q;
  assign mem_wr_data_o         = mem_wr_data_q;
  assign mem_req_access_size_o = mem_req_access_size_q;
  assign busy_o                = (state_q != IDLE);
  assign err_o                 = err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the CPU's single memory port between the instruction-cache fill path and the data-cache fill/writeback path. It sits between the two caches inside `cpu` and the external `mem` block. It drives the `rd_req_valid`/`wr_req_valid`/`req_is_instr`/`req_address`/`wr_data`/`req_access_size` bundle, routes each line response back to the requester that owns it, and guarantees the instruction side cannot be starved by back-to-back data misses.

## Interface
- ADDR_WIDTH, 32, byte address width.
- LINE_BITS, 128, cache line width in bits (CACHE_LINE_BYTES*8).
- SIZE_WIDTH, 2, width of the access-size encoding (passed through unchanged).
- STARVE_LIMIT, 4, maximum consecutive dcache grants allowed while an icache request is pending (≥1).
- LINE_SIZE_CODE, 2'b11, access-size code sent with every icache request.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- ic_rd_req_i  in  1  icache line-fill request (level).
- ic_addr_i  in  ADDR_WIDTH  icache fill address.
- ic_rsp_valid_o  out  1  one-cycle pulse: icache fill data valid.
- ic_rsp_data_o  out  LINE_BITS  icache fill data.
- dc_rd_req_i  in  1  dcache fill request (level).
- dc_wr_req_i  in  1  dcache writeback request (level).
- dc_addr_i  in  ADDR_WIDTH  dcache address.
- dc_wr_data_i  in  LINE_BITS  writeback data.
- dc_size_i  in  SIZE_WIDTH  dcache access size.
- dc_rsp_valid_o  out  1  one-cycle pulse: dcache fill data valid.
- dc_rsp_data_o  out  LINE_BITS  dcache fill data.
- dc_wr_done_o  out  1  one-cycle pulse: writeback complete.
- mem_rd_req_valid_o  out  1  memory read request.
- mem_wr_req_valid_o  out  1  memory write request.
- mem_req_is_instr_o  out  1  request belongs to icache.
- mem_req_address_o  out  ADDR_WIDTH  request address.
- mem_wr_data_o  out  LINE_BITS  write data.
- mem_req_access_size_o  out  SIZE_WIDTH  access size.
- mem_data_valid_i  in  1  read response pulse.
- mem_data_is_instr_i  in  1  read response tag.
- mem_data_i  in  LINE_BITS  read response data.
- mem_write_done_i  in  1  write response pulse.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky protocol error.

## Operation
- FSM states: IDLE, IC_RD, DC_RD, DC_WR, RESP.
- In IDLE, the arbiter samples the requests and picks one winner. All request fields are latched into registers. Next state is IC_RD, DC_RD or DC_WR.
- Priority (highest first):
  1. icache, if pending and `streak == STARVE_LIMIT`.
  2. dcache write.
  3. dcache read.
  4. icache.
- If dc_wr and dc_rd are both asserted, the write is serviced first and the read stays pending.
- `streak` counter (width clog2(STARVE_LIMIT+1)):
  - increments on a dcache grant while ic_rd_req_i=1;
  - clears on an icache grant;
  - clears on a dcache grant while ic_rd_req_i=0;
  - saturates at STARVE_LIMIT.
- IC_RD / DC_RD:
  - hold mem_rd_req_valid_o=1 with the latched address.
  - mem_req_is_instr_o=1 only in IC_RD.
  - Size is LINE_SIZE_CODE for icache and the latched dc_size_i for dcache.
  - On mem_data_valid_i: capture mem_data_i, go to RESP.
- DC_WR: hold mem_wr_req_valid_o=1 with the latched address/data/size. On mem_write_done_i: go to RESP.
- RESP, one cycle:
  - pulse exactly one of ic_rsp_valid_o, dc_rsp_valid_o or dc_wr_done_o, with the captured data;
  - then go to IDLE.
- A requester must deassert its request in the cycle after its response pulse. RESP guarantees the arbiter never samples a stale request.
- err_o is set, and stays set until reset, when:
  - mem_data_is_instr_i mismatches the state (1 in DC_RD, 0 in IC_RD);
  - mem_data_valid_i arrives in DC_WR;
  - mem_write_done_i arrives in IC_RD/DC_RD;
  - any memory response arrives in IDLE or RESP.
- A mismatched response still completes the transaction; stray responses are otherwise ignored.

## Timing
- Reset values:
  - state=IDLE, streak=0, err_o=0;
  - all mem_* request outputs 0;
  - all rsp/done pulses 0;
  - rsp data 0.
- Request seen in IDLE at cycle 0 → mem request valid from cycle 1, held through the memory-response cycle k inclusive.
- The memory must accept the held level as a single request and must not re-issue in cycle k.
- Response pulse to the requester at cycle k+1; IDLE at k+2. The earliest next grant is sampled at k+2, with its mem request at k+3.
- With a 1-cycle memory (k=2), a transaction takes 3 cycles plus 1 cycle in IDLE.
- Outputs are registered. Requester inputs are sampled only in IDLE; changes during service are ignored.
- Reset mid-transaction returns to IDLE on the next edge with all outputs at reset values, and the pending transaction is dropped. `mem` shares rst, so no stale response follows.

## Test plan
- Single icache fill at 0x40, memory answers 2 cycles later with 0x...DEAD → mem_rd_req_valid_o=1 and is_instr=1 for cycles 1–2, ic_rsp_valid_o pulses at cycle 3 with 0x...DEAD, busy_o=0 at cycle 4.
- dc_wr (0x100) and dc_rd (0x200) asserted together with ic idle → write issued first, dc_wr_done_o pulses, then read to 0x200 issues, dc_rsp_valid_o pulses; exactly 2 memory requests.
- ic_rd held while dc_rd requests back-to-back, STARVE_LIMIT=4 → 4 dcache grants, then the icache grant; streak returns to 0.
- Response with mem_data_is_instr_i=1 during DC_RD → dc_rsp_valid_o still pulses, err_o=1 and stays 1 until reset.
- rst=0 asserted during DC_WR → next cycle mem_wr_req_valid_o=0, busy_o=0, no dc_wr_done_o; after release, a new ic request is served normally.
- mem_write_done_i asserted in IDLE → err_o=1, no response pulse, state stays IDLE.
